// File: rtl/iter_mult_wb_pkg.sv
// Shared definitions for the iterative shift-add multiply / write-back stage.
// Holds the FSM state encoding, default widths and the N/Z flag positions
// as they sit in the cspr word.
package iter_mult_wb_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_CNT_W  = 6;

  // N and Z positions within the 32-bit cspr word
  localparam int unsigned CSPR_N_BIT = 31;
  localparam int unsigned CSPR_Z_BIT = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
  } nz_flags_t;

  // Place the N/Z flags at their cspr bit positions
  function automatic logic [31:0] cspr_place(input nz_flags_t f);
    logic [31:0] w;
    w             = '0;
    w[CSPR_N_BIT] = f.n;
    w[CSPR_Z_BIT] = f.z;
    return w;
  endfunction

  // Pull the N/Z flags back out of a cspr word
  function automatic nz_flags_t cspr_extract(input logic [31:0] w);
    nz_flags_t f;
    f.n = w[CSPR_N_BIT];
    f.z = w[CSPR_Z_BIT];
    return f;
  endfunction

endpackage

// File: rtl/iter_mult_datapath.sv
// Shift-add multiply datapath: accumulator, shifting multiplicand and
// multiplier, and iteration counter.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   load_i         capture operands, clear acc and count
//   step_i         perform one multiplier-bit iteration
//   mcand_i        multiplicand operand
//   mplier_i       multiplier operand
//   acc_o          accumulated partial product (registered)
//   done_c_o       combinational: iteration finished, acc_o holds the product
// Build option: ITER_MULT_EARLY_TERM_EN ends iteration once no multiplier
// bits remain set.
module iter_mult_datapath #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic [DATA_W-1:0] acc_o,
  output logic              done_c_o
);

  logic [DATA_W-1:0] acc_q,    acc_d;
  logic [DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  // Next-state: load has priority over step
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      count_d  = '0;
    end else if (step_i) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  // Finished after DATA_W steps; with early termination also once at least
  // one step has run and the shifted multiplier has no set bits left.
`ifdef ITER_MULT_EARLY_TERM_EN
  always_comb begin
    done_c_o = (count_q == CNT_W'(DATA_W)) ||
               ((count_q != '0) && (mplier_q == '0));
  end
`else
  always_comb begin
    done_c_o = (count_q == CNT_W'(DATA_W));
  end
`endif

  assign acc_o = acc_q;

endmodule

// File: rtl/iter_mult_wb.sv
// Sequential shift-add multiplier sitting between the register-file read
// ports and the write-back port. Accepts Rs/Rm plus a destination index,
// iterates one multiplier bit per clock, then holds a write-back request
// until the register file acknowledges it.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   op_valid / op_ready   operand handshake (op_ready high only when idle)
//   rs_data, rm_data      multiplicand, multiplier
//   dest_addr             write-back register index
//   busy                  operation in flight (MUL or WB)
//   wb_req, wb_address,
//   wb_data, wb_ack       write-back request, index, low product bits, accept
//   flag_n, flag_z        N/Z of the last written product
// Build option: ITER_MULT_EARLY_TERM_EN shortens MUL to the highest set
// multiplier bit (minimum one iteration).
module iter_mult_wb
  import iter_mult_wb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rm_data,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              busy,
  output logic              wb_req,
  output logic [ADDR_W-1:0] wb_address,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ack,
  output logic              flag_n,
  output logic              flag_z
);

  state_e            state_q,    state_d;
  logic              op_ready_q, op_ready_d;
  logic              busy_q,     busy_d;
  logic              wb_req_q,   wb_req_d;
  logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;
  nz_flags_t         flags_q,    flags_d;

  logic              dp_load;
  logic              dp_step;
  logic [DATA_W-1:0] dp_acc;
  logic              dp_done_c;

  iter_mult_datapath #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .mcand_i  (rs_data),
    .mplier_i (rm_data),
    .acc_o    (dp_acc),
    .done_c_o (dp_done_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    op_ready_d = op_ready_q;
    busy_d     = busy_q;
    wb_req_d   = wb_req_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    flags_d    = flags_q;
    dp_load    = 1'b0;
    dp_step    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          dp_load    = 1'b1;
          wb_addr_d  = dest_addr;
          op_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = MUL;
        end
      end
      MUL: begin
        // Product is complete once the datapath reports done; otherwise iterate
        if (dp_done_c) begin
          wb_data_d = dp_acc;
          wb_req_d  = 1'b1;
          state_d   = WB;
        end else begin
          dp_step = 1'b1;
        end
      end
      WB: begin
        if (wb_ack) begin
          wb_req_d   = 1'b0;
          flags_d.n  = wb_data_q[DATA_W-1];
          flags_d.z  = (wb_data_q == '0);
          busy_d     = 1'b0;
          op_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        wb_req_d   = 1'b0;
        busy_d     = 1'b0;
        op_ready_d = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      wb_req_q   <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_ready_q <= op_ready_d;
      busy_q     <= busy_d;
      wb_req_q   <= wb_req_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      flags_q    <= flags_d;
    end
  end

  assign op_ready   = op_ready_q;
  assign busy       = busy_q;
  assign wb_req     = wb_req_q;
  assign wb_address = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign flag_n     = flags_q.n;
  assign flag_z     = flags_q.z;

endmodule

// File: tb/tb_iter_mult_wb.sv
// Directed bench for iter_mult_wb: reset, products, flags, latency,
// write-back hold, ignored handshakes, back-to-back chain, mid-op reset.
module tb_iter_mult_wb;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] rs_data;
  logic [31:0] rm_data;
  logic [3:0]  dest_addr;
  logic        busy;
  logic        wb_req;
  logic [3:0]  wb_address;
  logic [31:0] wb_data;
  logic        wb_ack;
  logic        flag_n;
  logic        flag_z;

  int n_checks = 0;
  int n_errors = 0;

  iter_mult_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .rs_data    (rs_data),
    .rm_data    (rm_data),
    .dest_addr  (dest_addr),
    .busy       (busy),
    .wb_req     (wb_req),
    .wb_address (wb_address),
    .wb_data    (wb_data),
    .wb_ack     (wb_ack),
    .flag_n     (flag_n),
    .flag_z     (flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles from accept edge to wb_req rising
  function automatic int exp_lat(input logic [31:0] rm);
`ifdef ITER_MULT_EARLY_TERM_EN
    int h;
    h = 0;
    for (int i = 0; i < 32; i++) if (rm[i]) h = i + 1;
    if (h < 1) h = 1;
    return h + 1;
`else
    return 33;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for one accept edge, then scramble the inputs
  task automatic start_op(input logic [31:0] rs, input logic [31:0] rm, input logic [3:0] d);
    rs_data   = rs;
    rm_data   = rm;
    dest_addr = d;
    op_valid  = 1'b1;
    tick();
    op_valid  = 1'b0;
    rs_data   = ~rs;
    rm_data   = ~rm;
    dest_addr = ~d;
  endtask

  // Count edges until wb_req is seen (bounded) and compare with expectation
  task automatic wait_req(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!wb_req && n < 100);
    chk(tag, 32'(n), 32'(exp));
  endtask

  task automatic finish_ack();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    chk("ack_clears_req", 32'(wb_req), 32'd0);
  endtask

  initial begin
    logic [31:0] val;
    int          hi_cnt;

    rst_n     = 1'b1;
    op_valid  = 1'b0;
    rs_data   = '0;
    rm_data   = '0;
    dest_addr = '0;
    wb_ack    = 1'b0;

    // Reset held, then released
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_wb_req",   32'(wb_req),   32'd0);
    chk("rst_wb_addr",  32'(wb_address), 32'd0);
    chk("rst_wb_data",  wb_data,       32'd0);
    chk("rst_flags",    {30'd0, flag_n, flag_z}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_op_ready", 32'(op_ready), 32'd1);
    chk("post_rst_wb_req",   32'(wb_req),   32'd0);

    // 2*2 with wb_ack tied high: one-cycle request
    wb_ack = 1'b1;
    start_op(32'd2, 32'd2, 4'd2);
    chk("mul_busy",     32'(busy),     32'd1);
    chk("mul_op_ready", 32'(op_ready), 32'd0);
    wait_req("lat_2x2", exp_lat(32'd2));
    chk("2x2_data", wb_data, 32'd4);
    chk("2x2_addr", 32'(wb_address), 32'd2);
    tick();
    wb_ack = 1'b0;
    chk("2x2_one_cycle_req", 32'(wb_req), 32'd0);
    chk("2x2_flags", {30'd0, flag_n, flag_z}, 32'd0);
    chk("2x2_idle_ready", 32'(op_ready), 32'd1);

    // All-ones squared truncates to 1
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5);
    wait_req("lat_ones", exp_lat(32'hFFFF_FFFF));
    chk("ones_data", wb_data, 32'd1);
    chk("ones_addr", 32'(wb_address), 32'd5);
    finish_ack();
    chk("ones_flags", {30'd0, flag_n, flag_z}, 32'd0);

    // Sign bit product sets N
    start_op(32'h8000_0000, 32'd1, 4'd15);
    wait_req("lat_msb", exp_lat(32'd1));
    chk("msb_data", wb_data, 32'h8000_0000);
    finish_ack();
    chk("msb_flags", {30'd0, flag_n, flag_z}, 32'd2);

    // Zero multiplier sets Z
    start_op(32'd7, 32'd0, 4'd3);
    wait_req("lat_zero", exp_lat(32'd0));
    chk("zero_data", wb_data, 32'd0);
    finish_ack();
    chk("zero_flags", {30'd0, flag_n, flag_z}, 32'd1);

    // Stall in WB, ignored op_valid during MUL and WB
    start_op(32'd3, 32'h0000_0105, 4'd9);
    repeat (3) tick();
    op_valid  = 1'b1;
    rs_data   = 32'd100;
    rm_data   = 32'd100;
    dest_addr = 4'd15;
    tick();
    op_valid  = 1'b0;
    chk("mul_ignore_ready", 32'(op_ready), 32'd0);
    chk("mul_ignore_busy",  32'(busy),     32'd1);
    wait_req("lat_stall", exp_lat(32'h0000_0105) - 4);
    for (int i = 0; i < 5; i++) begin
      op_valid = 1'b1;
      tick();
      chk("hold_req",   32'(wb_req),     32'd1);
      chk("hold_data",  wb_data,         32'h0000_030F);
      chk("hold_addr",  32'(wb_address), 32'd9);
      chk("hold_ready", 32'(op_ready),   32'd0);
    end
    op_valid = 1'b0;
    chk("hold_flags_unchanged", {30'd0, flag_n, flag_z}, 32'd1);
    finish_ack();
    chk("stall_idle_ready", 32'(op_ready), 32'd1);
    chk("stall_idle_busy",  32'(busy),     32'd0);
    chk("stall_flags", {30'd0, flag_n, flag_z}, 32'd0);
    chk("idle_data_retained", wb_data, 32'h0000_030F);

    // Next op accepted one cycle after the ack edge
    start_op(32'd4, 32'd6, 4'd1);
    chk("next_accept_busy",  32'(busy),     32'd1);
    chk("next_accept_ready", 32'(op_ready), 32'd0);
    wait_req("lat_next", exp_lat(32'd6));
    chk("next_data", wb_data, 32'd24);
    chk("next_addr", 32'(wb_address), 32'd1);
    finish_ack();

    // Back-to-back doubling chain
    val = 32'd2;
    for (int i = 0; i < 10; i++) begin
      start_op(val, 32'd2, 4'd7);
      wait_req("lat_chain", exp_lat(32'd2));
      val = wb_data;
      finish_ack();
    end
    chk("chain_final", val, 32'd2048);

    // Reset in the middle of MUL aborts the operation
    start_op(32'd5, 32'hFFFF_FFFF, 4'd4);
    repeat (1) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",     32'(busy),     32'd0);
    chk("midrst_op_ready", 32'(op_ready), 32'd1);
    chk("midrst_wb_data",  wb_data,       32'd0);
    tick();
    rst_n  = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wb_req) hi_cnt++;
    end
    chk("midrst_no_req", 32'(hi_cnt), 32'd0);
    chk("midrst_idle_ready", 32'(op_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iter_mult_wb.md
Name: iter_mult_wb

Overview:
- Sequential shift-add multiply stage between the register-file read ports and the register-file write-back port.
- Takes Rs/Rm operand values plus a destination register address.
- Iterates one multiplier bit per clock, then holds a write-back request until the register file acknowledges it.
- Replaces the current combinational multiplier and the hand-sequenced result feedback loop.

Parameters:
- DATA_W, 32, operand/result width.
- ADDR_W, 4, register address width (16 registers).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  operands and destination presented.
- op_ready  out  1  unit idle and able to accept.
- rs_data  in  DATA_W  multiplicand (from out_data1).
- rm_data  in  DATA_W  multiplier (from out_data2).
- dest_addr  in  ADDR_W  write-back register index.
- busy  out  1  operation in flight (MUL or WB).
- wb_req  out  1  write-back request (drives write_enable).
- wb_address  out  ADDR_W  write-back register index.
- wb_data  out  DATA_W  product, low DATA_W bits.
- wb_ack  in  1  register file accepted the write.
- flag_n  out  1  result bit DATA_W-1 of the last written product.
- flag_z  out  1  last written product == 0.

Behaviour:
- Reset (asynchronous, rst_n=0), effective immediately:
  - state=IDLE, op_ready=1, busy=0, wb_req=0.
  - wb_address=0, wb_data=0, flag_n=0, flag_z=0.
  - Internal acc/mcand/mplier/count cleared.
- Reset mid-operation aborts with no write-back; the operation is lost.
- FSM has states IDLE, MUL and WB.
- IDLE:
  - op_ready=1.
  - On op_valid: latch mcand=rs_data, mplier=rm_data, wb_address=dest_addr; set acc=0, count=0; go to MUL.
- MUL:
  - op_ready=0, busy=1.
  - Each cycle: if mplier[0] then acc=acc+mcand (mod 2^DATA_W).
  - Then mcand<<=1, mplier>>=1, count++.
  - After exactly DATA_W MUL cycles, go to WB with wb_data=acc (final add included).
- WB:
  - wb_req=1; wb_address and wb_data held stable.
  - On the cycle wb_ack=1: next edge clears wb_req, updates flag_n/flag_z from wb_data, and returns to IDLE.
  - wb_req stays high indefinitely until wb_ack.
- Latency:
  - Accept edge T, wb_req rises at edge T+DATA_W+1.
  - Earliest next accept is one cycle after the wb_ack edge.
- Arithmetic:
  - Product truncated to the low DATA_W bits.
  - The low bits are identical for signed and unsigned operands; no overflow indication.
- Boundaries and simultaneous events:
  - op_valid while busy: ignored, op_ready=0, no latch.
  - wb_ack outside WB: ignored.
  - Operand inputs changing after the accept edge: no effect.
  - wb_data and wb_address retain their last value in IDLE; wb_req alone qualifies them.
  - flag_n/flag_z change only on a completed write-back.

Optional Feature:
- Macro: ITER_MULT_EARLY_TERM_EN.
- When defined: MUL exits to WB on the edge where the shifted mplier becomes 0, or when count reaches DATA_W, whichever comes first.
  - MUL always lasts at least 1 cycle, so rm_data=0 takes exactly 1 MUL cycle.
  - Latency becomes max(1, index of highest set bit of rm_data + 1) + 1 cycles to wb_req.
- When undefined: fixed DATA_W-cycle MUL. The early-termination comparator is absent from the netlist.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, MUL, WB);
  - DATA_W/ADDR_W defaults;
  - the flag bit positions matching the cspr layout.
- One natural sub-module, iter_mult_datapath: acc/mcand/mplier registers, adder and shifters, with load/step controls.
- The FSM and write-back handshake stay in the top module.

Test Plan:
- Reset held, then released → op_ready=1, wb_req=0, all outputs 0. Reset asserted mid-MUL → immediate IDLE, no wb_req ever asserted for that operation.
- rs=2, rm=2, dest=2, wb_ack tied high → wb_req at accept+33 (early-term: accept+3), wb_data=4, wb_address=2, one-cycle wb_req, flag_z=0, flag_n=0.
- rs=32'hFFFFFFFF, rm=32'hFFFFFFFF → wb_data=1, flag_n=0. Then rs=32'h80000000, rm=1 → wb_data=32'h80000000, flag_n=1.
- rs=7, rm=0 → wb_data=0, flag_z=1. With the early-term macro, wb_req at accept+2.
- wb_ack held low 5 cycles in WB → wb_req, wb_data and wb_address stable throughout. op_valid pulsed during MUL and WB → not accepted. After wb_ack, the next op is accepted one cycle later.
- Back-to-back chain feeding each wb_data into rs with rm=2, repeated 10 times from 2 → final wb_data=2048.
